flight_call_panel: RTL

Multi-seat successor to the single-seat flight call button. One latched call light per seat; passengers set it with `call` and clear it with `cncl`. A round-robin server presents one pending seat at a time to the attendant, who clears it with `ack`. Seats left unanswered for `TMO_CYCLES` escalate and are served ahead of normal calls. Sits between the seat button debouncers and the galley attendant panel.

---
 rtl/flight_call_panel.sv | 135 +++++++++++++
 1 files changed

// File: rtl/flight_call_panel.sv
// Per-seat latched call lights with escalation timers and a sticky round-robin server
// that offers one pending seat at a time to the attendant panel.
module flight_call_panel #(
  parameter int N_SEATS    = 8,
  parameter int TMO_CYCLES = 100,
  parameter int SEL_W      = $clog2(N_SEATS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_SEATS-1:0]             call,
  input  logic [N_SEATS-1:0]             cncl,
  input  logic                           ack,
  output logic [N_SEATS-1:0]             L,
  output logic                           srv_valid,
  output logic [SEL_W-1:0]               srv_seat,
  output logic                           esc,
  output logic [N_SEATS-1:0]             esc_vec,
  output logic [$clog2(N_SEATS+1)-1:0]   n_active
);

  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam int CW = $clog2(N_SEATS + 1);
  localparam logic [TW-1:0] TMO = TW'(TMO_CYCLES);
  localparam logic [0:0] S_OFF = 1'b0;
  localparam logic [0:0] S_ON  = 1'b1;

  logic [N_SEATS-1:0] on_q, on_d;
  logic [TW-1:0]      tmr_q [N_SEATS];
  logic [TW-1:0]      tmr_d [N_SEATS];
  logic               srv_valid_q, srv_valid_d;
  logic [SEL_W-1:0]   srv_seat_q, srv_seat_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               ack_ok;
  logic [N_SEATS-1:0] served, drop, cand_base, cand_esc, cand;
  logic               found;
  logic [SEL_W-1:0]   pick;
  logic [CW-1:0]      cnt;
  int                 idx;

  assign ack_ok = ack && srv_valid_q;

  // A call on the same edge as ack/cncl keeps the seat lit; ack+call restarts its timer.
  always_comb begin
    served = '0;
    drop   = '0;
    on_d   = on_q;
    for (int i = 0; i < N_SEATS; i++) begin
      served[i] = ack_ok && (srv_seat_q == SEL_W'(i));
      drop[i]   = (on_q[i] == S_ON) && !call[i] && (cncl[i] || served[i]);
      on_d[i]   = call[i] ? S_ON : (drop[i] ? S_OFF : on_q[i]);
      tmr_d[i]  = tmr_q[i];
      if (on_d[i] == S_OFF || (call[i] && (on_q[i] == S_OFF || served[i]))) begin
        tmr_d[i] = '0;
      end else if (tmr_q[i] != TMO) begin
        tmr_d[i] = tmr_q[i] + TW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SEATS; i++) begin
      esc_vec[i] = (tmr_q[i] == TMO);
    end
  end

  // Seats extinguished on this edge are never offered, so a grant always names a lit seat.
  assign cand_base = on_q & ~drop;
  assign cand_esc  = cand_base & esc_vec;
  assign cand      = (|cand_esc) ? cand_esc : cand_base;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_SEATS; k++) begin
      idx = (int'(ptr_q) + k) % N_SEATS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    srv_valid_d = srv_valid_q;
    srv_seat_d  = srv_seat_q;
    ptr_d       = ptr_q;
    if (srv_valid_q) begin
      if (ack) begin
        srv_valid_d = 1'b0;
        ptr_d = (srv_seat_q == SEL_W'(N_SEATS - 1)) ? '0 : srv_seat_q + SEL_W'(1);
      end else if (drop[srv_seat_q]) begin
        srv_valid_d = 1'b0;
      end
    end else if (found) begin
      srv_valid_d = 1'b1;
      srv_seat_d  = pick;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_SEATS; i++) begin
      cnt = cnt + CW'(on_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_q        <= '0;
      srv_valid_q <= 1'b0;
      srv_seat_q  <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < N_SEATS; i++) begin
        tmr_q[i] <= '0;
      end
    end else begin
      on_q        <= on_d;
      srv_valid_q <= srv_valid_d;
      srv_seat_q  <= srv_seat_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < N_SEATS; i++) begin
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign L         = on_q;
  assign srv_valid = srv_valid_q;
  assign srv_seat  = srv_seat_q;
  assign esc       = |esc_vec;
  assign n_active  = cnt;

endmodule
